irr_priority_resolver: RTL
==========================

// Module: irr_priority_resolver
// PURPOSE
//  Interrupt Request Register (IRR) plus Priority Resolver for the 8259A PIC.
//  Directly upstream of the In-Service Register: samples IR0-IR7, applies the mask (IMR),
//  picks the highest-priority eligible request, raises INT and drives toSet / zeroLevelIndex.
//  Tracks rotating priority driven by EOI and set-priority commands.
// PARAMETERS
//  SYNC_STAGES  2  flip-flop stages on each ir[] line before edge/level detection (legal: 1-3)
// PORTS
//  clk               in   1  system clock
//  rst_n             in   1  asynchronous active-low reset
//  ir                in   8  raw interrupt request lines IR0-IR7
//  levelTriggered    in   1  ICW1 LTIM: 1 = level mode, 0 = rising-edge mode
//  imr               in   8  OCW1 interrupt mask, 1 = masked
//  isrRegValue       in   8  current ISR contents
//  firstAck          in   1  1-cycle pulse, first INTA (ISR readPriority)
//  secondAck         in   1  1-cycle pulse, second INTA
//  eoiValid          in   1  1-cycle pulse, ISR just cleared resetedIndex
//  resetedIndex      in   3  ISR bit cleared by the EOI
//  rotateOnEoi       in   1  1 = rotate priority on each eoiValid
//  setPriority       in   1  1-cycle pulse, OCW2 set-priority command (R=1, SL=1, EOI=0)
//  priorityLevel     in   3  OCW2 L2-L0, the new lowest-priority line
//  specialMask       in   1  OCW3 SMM (effective only with SPECIAL_MASK_EN)
//  INT               out  1  interrupt request to CPU, registered
//  toSet             out  3  index of the winning request, registered
//  zeroLevelIndex    out  3  current highest-priority line
//  irrValue          out  8  IRR contents, for OCW3 read-back
//  spurious          out  1  1 = last firstAck found no eligible request
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - Synchronisers, IRR, INT, toSet, spurious and the ack-busy flag go to 0.
//   - zeroLevelIndex goes to 0, so IR0 is highest priority.
//  Sampling: irS = ir delayed SYNC_STAGES clocks. irPrev holds irS from the previous cycle.
//  IRR update, each clock:
//   - Edge mode: set bit i when irS[i] & ~irPrev[i]. Clear bit i on firstAck when i == toSet.
//     If set and clear hit the same bit in the same cycle, set wins.
//   - Level mode: IRR = irS. firstAck does not clear IRR.
//  Eligibility: eligible = IRR & ~imr. Priority order is zeroLevelIndex, +1, ... wrapping mod 8.
//  Fully nested check:
//   - win = highest-priority eligible bit.
//   - INT_next = 1 when win exists and is strictly higher priority than the highest set ISR bit.
//     An empty ISR counts as lowest.
//  Registered outputs:
//   - INT and toSet register INT_next and win, one clock after the IRR change.
//   - Latency from ir edge to INT is SYNC_STAGES+2 clocks.
//  Ack window: firstAck sets ackBusy, secondAck clears it.
//   - While ackBusy=1, toSet is frozen and INT is forced to 0.
//   - A second firstAck inside the window is ignored.
//   - secondAck without a prior firstAck has no effect.
//  Spurious: if firstAck arrives with no eligible request, then on the next clock
//   toSet=3'd7 and spurious=1. spurious clears on the next firstAck that has a winner.
//  Rotation:
//   - eoiValid & rotateOnEoi: zeroLevelIndex <= resetedIndex+1 mod 8.
//   - setPriority: zeroLevelIndex <= priorityLevel+1 mod 8.
//   - If both pulse in the same cycle, setPriority wins. Both wrap 7 -> 0.
//  Mask change takes effect on INT one clock later. A masked pending request stays in IRR.
// CONFIGURATION
//  SPECIAL_MASK_EN defined:
//   - When specialMask=1, ISR bits whose IMR bit is set are ignored in the nested check.
//   - Any unmasked request not in service may then interrupt, regardless of its priority.
//  SPECIAL_MASK_EN undefined: specialMask is ignored and the strict fully nested check applies.
// TESTING
//  1. Edge mode, imr=0, ISR=0, ir=8'h08 rising -> INT=1 at clk SYNC_STAGES+2 with toSet=3;
//     firstAck -> irrValue[3]=0 and INT=0 until secondAck.
//  2. ISR=8'h04, IR5 and IR1 requested -> toSet=1, INT=1. Same with only IR5 -> INT stays 0.
//  3. Level mode, ir[6] held high through firstAck -> irrValue[6]=1 throughout;
//     ir[6] dropped -> irrValue[6]=0 after SYNC_STAGES+1 clocks.
//  4. rotateOnEoi=1, eoiValid with resetedIndex=7 -> zeroLevelIndex=0;
//     setPriority with priorityLevel=2 -> zeroLevelIndex=3; IR1 and IR4 pending -> toSet=4.
//  5. firstAck with IRR=0 -> toSet=7, spurious=1. Assert rst_n=0 mid-ack ->
//     IRR, INT and spurious all 0 immediately, zeroLevelIndex=0.
//  6. SPECIAL_MASK_EN, specialMask=1, imr=8'h01, ISR=8'h01, IR4 pending -> INT=1, toSet=4.
//     Without the macro -> INT=0.

Source files
------------

// File: rtl/irr_priority_resolver.sv
// Interrupt request register and rotating priority resolver for an 8259A-style PIC.
// Optional feature macro: SPECIAL_MASK_EN (OCW3 special mask mode in the nested check).
module irr_priority_resolver #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       levelTriggered,
  input  logic [7:0] imr,
  input  logic [7:0] isrRegValue,
  input  logic       firstAck,
  input  logic       secondAck,
  input  logic       eoiValid,
  input  logic [2:0] resetedIndex,
  input  logic       rotateOnEoi,
  input  logic       setPriority,
  input  logic [2:0] priorityLevel,
  input  logic       specialMask,
  output logic       INT,
  output logic [2:0] toSet,
  output logic [2:0] zeroLevelIndex,
  output logic [7:0] irrValue,
  output logic       spurious
);

  logic [7:0] syncQ [SYNC_STAGES];
  logic [7:0] irS;
  logic [7:0] irPrevQ;
  logic [7:0] irrQ, irrD;
  logic       intQ, intD;
  logic [2:0] toSetQ, toSetD;
  logic [2:0] zeroLevelQ, zeroLevelD;
  logic       spuriousQ, spuriousD;
  logic       ackBusyQ, ackBusyD;

  logic [7:0] eligible;
  logic [7:0] isrEff;
  logic [2:0] scanIdx;
  logic       winValid, isrValid;
  logic [2:0] winLevel, isrLevel, winIndex;
  logic       intNext;
  logic       ackAccept;

  assign irS = syncQ[SYNC_STAGES-1];

`ifdef SPECIAL_MASK_EN
  // In special mask mode, masked in-service levels no longer block lower priorities.
  assign isrEff = specialMask ? (isrRegValue & ~imr) : isrRegValue;
`else
  logic unusedSpecialMask;
  assign unusedSpecialMask = specialMask;
  assign isrEff = isrRegValue;
`endif

  // Priority levels are counted from zeroLevelQ; the lowest level found wins.
  always_comb begin
    eligible = irrQ & ~imr;
    winValid = 1'b0;
    isrValid = 1'b0;
    winLevel = 3'd0;
    isrLevel = 3'd0;
    scanIdx  = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      scanIdx = zeroLevelQ + 3'(k);
      if (eligible[scanIdx]) begin
        winValid = 1'b1;
        winLevel = 3'(k);
      end
      if (isrEff[scanIdx]) begin
        isrValid = 1'b1;
        isrLevel = 3'(k);
      end
    end
    winIndex = zeroLevelQ + winLevel;
    intNext  = winValid & (~isrValid | (winLevel < isrLevel));
  end

  always_comb begin
    ackAccept = firstAck & ~ackBusyQ;

    irrD = irrQ;
    if (levelTriggered) begin
      irrD = irS;
    end else begin
      if (ackAccept && winValid) irrD[toSetQ] = 1'b0;
      // Applied after the ack clear so a simultaneous new edge wins.
      irrD = irrD | (irS & ~irPrevQ);
    end

    ackBusyD = ackBusyQ;
    if (ackAccept) begin
      ackBusyD = 1'b1;
    end else if (secondAck) begin
      ackBusyD = 1'b0;
    end

    toSetD    = toSetQ;
    spuriousD = spuriousQ;
    if (ackAccept) begin
      if (!winValid) toSetD = 3'd7;
      spuriousD = ~winValid;
    end else if (!ackBusyQ && winValid) begin
      toSetD = winIndex;
    end

    intD = intNext & ~ackBusyD;

    zeroLevelD = zeroLevelQ;
    if (setPriority) begin
      zeroLevelD = priorityLevel + 3'd1;
    end else if (eoiValid && rotateOnEoi) begin
      zeroLevelD = resetedIndex + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) syncQ[s] <= 8'd0;
      irPrevQ    <= 8'd0;
      irrQ       <= 8'd0;
      intQ       <= 1'b0;
      toSetQ     <= 3'd0;
      zeroLevelQ <= 3'd0;
      spuriousQ  <= 1'b0;
      ackBusyQ   <= 1'b0;
    end else begin
      syncQ[0] <= ir;
      for (int s = 1; s < SYNC_STAGES; s++) syncQ[s] <= syncQ[s-1];
      irPrevQ    <= irS;
      irrQ       <= irrD;
      intQ       <= intD;
      toSetQ     <= toSetD;
      zeroLevelQ <= zeroLevelD;
      spuriousQ  <= spuriousD;
      ackBusyQ   <= ackBusyD;
    end
  end

  assign INT            = intQ;
  assign toSet          = toSetQ;
  assign zeroLevelIndex = zeroLevelQ;
  assign irrValue       = irrQ;
  assign spurious       = spuriousQ;

endmodule
